// File: rtl/jarvis_pkg.sv
// Shared types for the memory arbiter.
// - arb_state_e : arbiter FSM state encoding (IDLE=0, BUSY_IF=1, BUSY_MA=2)
// - cnt_width   : bit width needed to count 0..limit (never less than 1)
package jarvis_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_MA = 2'd2
  } arb_state_e;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive memacc grants taken while fetch waits.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   inc        : memacc granted while fetch was requesting
//   clr        : fetch granted, or fetch not requesting
//   sat        : counter has reached LIMIT (fetch must win next)
module starve_counter
  import jarvis_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned W = cnt_width(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == W'(LIMIT));

  // Clear wins over increment; the count holds once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (inc && !sat) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (if_*) and memory access
// (ma_*) share one memory port with at most one transaction outstanding.
// Memacc wins ties unless fetch has been passed over STARVE_LIMIT times.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata      : fetch side
//   ma_req/ma_we/ma_addr/ma_wdata -> ma_gnt/...      : memacc side
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ready,
//   mem_rvalid/mem_rdata               : memory side
//   stall_if, stall_ma                 : pipeline hold for each requester
module mem_arbiter
  import jarvis_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch side
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  // memacc side
  input  logic          ma_req,
  input  logic          ma_we,
  input  logic [AW-1:0] ma_addr,
  input  logic [31:0]   ma_wdata,
  output logic          ma_gnt,
  output logic          ma_rvalid,
  output logic [31:0]   ma_rdata,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  // stage holds
  output logic          stall_if,
  output logic          stall_ma
);

  arb_state_e state_q, state_d;
  logic       sat;
  logic       sel_if;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ma_gnt && if_req),
    .clr   (if_gnt || !if_req),
    .sat   (sat)
  );

  // All outputs are gated by rst_n so the requester-driven combinational
  // paths (mem_req, stalls) read 0 while reset is held.
  always_comb begin
    state_d   = state_q;
    sel_if    = if_req && (!ma_req || sat);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_gnt    = 1'b0;
    ma_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ma_rvalid = 1'b0;
    if_rdata  = '0;
    ma_rdata  = '0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          // Requests are presented combinationally; nothing is captured,
          // the requester holds its inputs until rvalid.
          mem_req = if_req || ma_req;
          if (sel_if) begin
            mem_addr = if_addr;
          end else if (ma_req) begin
            mem_addr  = ma_addr;
            mem_we    = ma_we;
            mem_wdata = ma_wdata;
          end
          if (mem_req && mem_ready) begin
            if_gnt  = sel_if;
            ma_gnt  = !sel_if;
            state_d = sel_if ? BUSY_IF : BUSY_MA;
          end
        end
        BUSY_IF: if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
          state_d   = IDLE;
        end
        BUSY_MA: if (mem_rvalid) begin
          ma_rvalid = 1'b1;
          ma_rdata  = mem_rdata;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_if = rst_n && if_req && !if_rvalid;
  assign stall_ma = rst_n && ma_req && !ma_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          ma_req, ma_we;
  logic [AW-1:0] ma_addr;
  logic [31:0]   ma_wdata;
  logic          ma_gnt, ma_rvalid;
  logic [31:0]   ma_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          stall_if, stall_ma;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_ma(stall_ma)
  );

  // Inputs change 1 time unit after the rising edge; outputs are
  // sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    ma_req = 0; ma_we = 0; ma_addr = '0; ma_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    if_req = 1; if_addr = 32'h1234; ma_req = 1; ma_we = 1;
    ma_addr = 32'h55; ma_wdata = 32'hFFFF_FFFF;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    checks++;
    if ({if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we, stall_if, stall_ma} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we, stall_if, stall_ma});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, ma_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, if_rdata, ma_rdata);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_idle_memreq got=%b exp=0", mem_req);
    end
    next_cycle();
  endtask

  task automatic test_fetch_only();
    clear_inputs();
    if_req = 1; if_addr = 32'h100; mem_ready = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_gnt, ma_gnt} !== 4'b1010 || mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL fetch_issue got=req%b we%b ig%b mg%b addr%h exp=1010 addr100",
               mem_req, mem_we, if_gnt, ma_gnt, mem_addr);
    end
    next_cycle();
    mem_ready = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, if_rvalid, stall_if} !== 3'b001) begin
      failures++; $display("FAIL fetch_wait got=%b exp=001", {mem_req, if_rvalid, stall_if});
    end
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0050_0093 || stall_if !== 1'b0 || ma_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_resp got=v%b d%h s%b mv%b exp=v1 d00500093 s0 mv0",
               if_rvalid, if_rdata, stall_if, ma_rvalid);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_conflict();
    clear_inputs();
    if_req = 1; if_addr = 32'h300; ma_req = 1; ma_addr = 32'h2000; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (ma_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL conflict_first got=mg%b ig%b addr%h we%b exp=mg1 ig0 addr2000 we0",
               ma_gnt, if_gnt, mem_addr, mem_we);
    end
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++;
    if (ma_rvalid !== 1'b1 || ma_rdata !== 32'hCAFE_0001 || if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL conflict_ma_resp got=mv%b d%h iv%b exp=mv1 dcafe0001 iv0", ma_rvalid, ma_rdata, if_rvalid);
    end
    next_cycle();
    ma_req = 0; mem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 32'h300) begin
      failures++; $display("FAIL conflict_fetch_next got=ig%b addr%h exp=ig1 addr300", if_gnt, mem_addr);
    end
    next_cycle();
    mem_rvalid = 1;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_starvation();
    bit exp_if;
    clear_inputs();
    if_req = 1; if_addr = 32'h1000; ma_req = 1; ma_addr = 32'h2000; mem_ready = 1;
    for (int g = 0; g < 10; g++) begin
      exp_if = (g % (LIMIT + 1)) == LIMIT;
      @(negedge clk);
      checks++;
      if (if_gnt !== exp_if || ma_gnt !== !exp_if || mem_addr !== (exp_if ? 32'h1000 : 32'h2000)) begin
        failures++;
        $display("FAIL starve_grant%0d got=ig%b mg%b addr%h exp=ig%b", g, if_gnt, ma_gnt, mem_addr, exp_if);
      end
      next_cycle();
      mem_rvalid = 1; mem_rdata = 32'(g);
      @(negedge clk);
      checks++;
      if (if_rvalid !== exp_if || ma_rvalid !== !exp_if) begin
        failures++;
        $display("FAIL starve_resp%0d got=iv%b mv%b exp=iv%b", g, if_rvalid, ma_rvalid, exp_if);
      end
      next_cycle();
      mem_rvalid = 0;
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    ma_req = 1; ma_we = 1; ma_addr = 32'h88; ma_wdata = 32'h1111_2222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || ma_gnt !== 1'b0 || mem_addr !== 32'h88 || stall_ma !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold%0d got=req%b mg%b addr%h st%b exp=req1 mg0 addr88 st1",
                 c, mem_req, ma_gnt, mem_addr, stall_ma);
      end
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk);
    checks++;
    if (ma_gnt !== 1'b1) begin
      failures++; $display("FAIL backpressure_gnt got=%b exp=1", ma_gnt);
    end
    next_cycle();
    mem_rvalid = 1;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_store();
    clear_inputs();
    ma_req = 1; ma_we = 1; ma_addr = 32'h40; ma_wdata = 32'hDEAD_BEEF; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (ma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL store_issue got=mg%b we%b wd%h addr%h exp=mg1 we1 wddeadbeef addr40",
               ma_gnt, mem_we, mem_wdata, mem_addr);
    end
    next_cycle();
    mem_ready = 0;
    @(negedge clk);
    checks++;
    if (ma_rvalid !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL store_wait got=mv%b req%b exp=mv0 req0", ma_rvalid, mem_req);
    end
    next_cycle();
    mem_rvalid = 1;
    @(negedge clk);
    checks++;
    if (ma_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
      failures++; $display("FAIL store_ack got=mv%b iv%b exp=mv1 iv0", ma_rvalid, if_rvalid);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_idle_rvalid_and_drop();
    clear_inputs();
    mem_rvalid = 1; mem_rdata = 32'h7777;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || ma_rvalid !== 1'b0) begin
      failures++; $display("FAIL idle_rvalid got=iv%b mv%b exp=0 0", if_rvalid, ma_rvalid);
    end
    next_cycle();
    mem_rvalid = 0;
    ma_req = 1; ma_addr = 32'h99;  // not accepted, then withdrawn
    next_cycle();
    ma_req = 0;
    mem_ready = 1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || ma_gnt !== 1'b0) begin
      failures++; $display("FAIL drop_quiet got=req%b mg%b exp=0 0", mem_req, ma_gnt);
    end
    next_cycle();
    if_req = 1; if_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++; $display("FAIL drop_still_idle got=%b exp=1", if_gnt);
    end
    next_cycle();
    mem_rvalid = 1;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    ma_req = 1; ma_addr = 32'h500; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (ma_gnt !== 1'b1) begin
      failures++; $display("FAIL rstmid_gnt got=%b exp=1", ma_gnt);
    end
    next_cycle();
    mem_ready = 0;
    next_cycle();
    rst_n = 0; if_req = 1; mem_rvalid = 1; mem_rdata = 32'hABC;
    @(negedge clk);
    checks++;
    if ({if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we, stall_if, stall_ma} !== 8'h00 ||
        {mem_addr, ma_rdata, if_rdata} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b addr%h exp=0",
               {if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we, stall_if, stall_ma}, mem_addr);
    end
    next_cycle();
    rst_n = 1; if_req = 0; ma_req = 0;  // late response arrives after reset
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || ma_rvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_late_rvalid got=iv%b mv%b exp=0 0", if_rvalid, ma_rvalid);
    end
    next_cycle();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h700; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 32'h700) begin
      failures++; $display("FAIL rstmid_idle got=ig%b addr%h exp=ig1 addr700", if_gnt, mem_addr);
    end
    next_cycle();
    mem_rvalid = 1;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  // Reference model: a transaction-level view of who owns the memory and
  // how many times fetch has been passed over while waiting.
  task automatic test_random(input int ncyc);
    int owner  = 0;   // 0 none, 1 fetch, 2 memacc
    int starve = 0;
    bit if_pend = 0, ma_pend = 0;
    bit e_req, pick_if, grant, e_ig, e_mg, e_iv, e_mv;
    clear_inputs();
    for (int c = 0; c < ncyc; c++) begin
      if (if_pend && owner != 1 && $urandom_range(9) == 0) if_pend = 0;
      else if (!if_pend && $urandom_range(9) < 4) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (ma_pend && owner != 2 && $urandom_range(9) == 0) ma_pend = 0;
      else if (!ma_pend && $urandom_range(9) < 5) begin
        ma_pend = 1; ma_we = 1'($urandom_range(1)); ma_addr = $urandom; ma_wdata = $urandom;
      end
      if_req     = if_pend;
      ma_req     = ma_pend;
      mem_ready  = $urandom_range(9) < 7;
      mem_rvalid = (owner != 0) ? ($urandom_range(2) == 0) : ($urandom_range(4) == 0);
      mem_rdata  = $urandom;
      @(negedge clk);
      e_req   = (owner == 0) && (if_req || ma_req);
      pick_if = if_req && (starve == LIMIT || !ma_req);
      grant   = e_req && mem_ready;
      e_ig    = grant && pick_if;
      e_mg    = grant && !pick_if;
      e_iv    = (owner == 1) && mem_rvalid;
      e_mv    = (owner == 2) && mem_rvalid;
      checks++;
      if ({mem_req, if_gnt, ma_gnt, if_rvalid, ma_rvalid, stall_if, stall_ma} !==
          {e_req, e_ig, e_mg, e_iv, e_mv, if_req && !e_iv, ma_req && !e_mv}) begin
        failures++;
        $display("FAIL rand_ctrl cyc%0d got=%b exp=%b", c,
                 {mem_req, if_gnt, ma_gnt, if_rvalid, ma_rvalid, stall_if, stall_ma},
                 {e_req, e_ig, e_mg, e_iv, e_mv, if_req && !e_iv, ma_req && !e_mv});
      end
      if (e_req) begin
        checks++;
        if (mem_addr !== (pick_if ? if_addr : ma_addr) || mem_we !== (!pick_if && ma_we) ||
            (!pick_if && ma_we && mem_wdata !== ma_wdata)) begin
          failures++;
          $display("FAIL rand_mux cyc%0d got=addr%h we%b wd%h exp_if=%b", c, mem_addr, mem_we, mem_wdata, pick_if);
        end
      end
      if (e_iv || (e_mv && !ma_we)) begin
        checks++;
        if ((e_iv ? if_rdata : ma_rdata) !== mem_rdata) begin
          failures++;
          $display("FAIL rand_rdata cyc%0d got=%h exp=%h", c, e_iv ? if_rdata : ma_rdata, mem_rdata);
        end
      end
      if (!if_req || e_ig) starve = 0;
      else if (e_mg) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      if (grant) owner = pick_if ? 1 : 2;
      else if (e_iv) begin owner = 0; if_pend = 0; end
      else if (e_mv) begin owner = 0; ma_pend = 0; end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_conflict();
    test_starvation();
    test_backpressure();
    test_store();
    test_idle_rvalid_and_drop();
    test_reset_mid();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive memacc grants while fetch waits before fetch is forced.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have ports `clk` (in, 1, single clock, all state on rising edge) and `rst_n` (in, 1); reset is asynchronous and active-low.
REQ-004 SHALL have fetch-side ports:
- `if_req` (in, 1): fetch request.
- `if_addr` (in, AW): fetch address.
- `if_gnt` (out, 1): fetch request accepted this cycle.
- `if_rvalid` (out, 1): fetch data valid.
- `if_rdata` (out, 32): instruction word.
REQ-005 SHALL have memacc-side ports:
- `ma_req` (in, 1), `ma_we` (in, 1), `ma_addr` (in, AW), `ma_wdata` (in, 32).
- `ma_gnt` (out, 1), `ma_rvalid` (out, 1), `ma_rdata` (out, 32).
REQ-006 SHALL have memory-side ports:
- `mem_req` (out, 1), `mem_we` (out, 1), `mem_addr` (out, AW), `mem_wdata` (out, 32).
- `mem_ready` (in, 1): memory accepts the request.
- `mem_rvalid` (in, 1): response or write ack.
- `mem_rdata` (in, 32).
REQ-007 SHALL have outputs `stall_if` and `stall_ma` (1 each): pipeline stage hold.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MA; at most one transaction outstanding.
REQ-009 In IDLE, SHALL drive `mem_req`=1 whenever `if_req` or `ma_req` is high, muxing addr/we/wdata from the selected requester (`mem_we`=0 for fetch).
REQ-010 Selection SHALL be memacc-first, except fetch SHALL be selected when `if_req`=1 and starve counter == STARVE_LIMIT.
REQ-011 Grant occurs in the IDLE cycle where `mem_req` && `mem_ready`: the winner's gnt pulses 1 cycle and the FSM moves to BUSY_IF/BUSY_MA next edge; if `mem_ready`=0 the FSM stays IDLE and re-arbitrates next cycle.
REQ-012 In BUSY_x, `mem_req` SHALL be 0; on `mem_rvalid`=1 SHALL pulse the owner's rvalid with rdata=`mem_rdata` combinationally, and return to IDLE next edge.
REQ-013 Writes complete on `mem_rvalid`; `ma_rvalid` pulses for writes too (`ma_rdata` don't-care).
REQ-014 `mem_rvalid` in IDLE SHALL be ignored, with no rvalid to either side.
REQ-015 Minimum transaction time SHALL be 3 cycles: issue, ≥1 wait, IDLE.
REQ-016 Starve counter behaviour:
- Width ceil(log2(STARVE_LIMIT+1)); saturates at STARVE_LIMIT.
- Increments on a memacc grant while `if_req`=1.
- Clears on a fetch grant or any cycle with `if_req`=0.
REQ-017 `stall_if` = `if_req` && !`if_rvalid`; `stall_ma` = `ma_req` && !`ma_rvalid`.
REQ-018 Requesters hold req/addr/data stable until their rvalid; the arbiter SHALL NOT latch requester inputs beyond the grant cycle.
REQ-019 Simultaneous `if_req` and `ma_req` with counter < STARVE_LIMIT SHALL grant memacc.
REQ-020 Request deasserted while not granted SHALL be dropped with no memory activity.

Reset
REQ-021 While `rst_n`=0: state IDLE, starve counter 0, all outputs 0.
REQ-022 Reset asserted mid-transaction SHALL abandon it; a late `mem_rvalid` after reset is ignored per REQ-014.

Structure
REQ-023 State encoding (IDLE=0, BUSY_IF=1, BUSY_MA=2) SHALL live in shared package `jarvis_pkg` as a typedef.
REQ-024 The starve counter SHALL be sub-module `starve_counter` (params LIMIT; ports clk, rst_n, inc, clr, sat).
REQ-025 Implementation SHALL be 120-400 lines, with no memory inferred inside.

Verification
REQ-026 Fetch-only: `if_req`=1, addr 0x100, `mem_ready`=1, `mem_rvalid` 2 cycles later with 0x00500093 -> `if_gnt` at cycle 0, `if_rvalid`/`if_rdata`=0x00500093 at cycle 2, `stall_if` low at cycle 2.
REQ-027 Conflict: both req same cycle, ma load 0x2000 -> `ma_gnt` first, `mem_addr`=0x2000, fetch granted in the next IDLE.
REQ-028 Starvation: `ma_req` continuously, `if_req` held, STARVE_LIMIT=4 -> 4 memacc grants then a fetch grant, counter cleared.
REQ-029 Backpressure: `mem_ready`=0 for 3 cycles -> no gnt, `mem_req` held, addr stable, gnt in the cycle `mem_ready` rises.
REQ-030 Store 0xDEADBEEF to 0x40 -> `mem_we`=1, `mem_wdata`=0xDEADBEEF, `ma_rvalid` on ack, `if_rvalid` stays 0.
REQ-031 Reset mid BUSY_MA, then `mem_rvalid` -> no rvalid output, FSM in IDLE, all outputs 0 during reset.
